// File: rtl/cobra_memmap_if.sv
// ----------------------------------------------------------------------------
// cobra_memmap_if
//
// Purpose:
//   Bundles the tv80s-side bus between the CPU core and the memory/I-O map
//   controller. The CPU drives address, strobes and write data. The map
//   controller returns read data and the wait request.
//
// Signals:
//   addr_raw  CPU address (ADDR_W bits)
//   mreq_n    memory request, active low
//   iorq_n    I/O request, active low
//   rd_n      read strobe, active low
//   wr_n      write strobe, active low
//   m1_n      opcode fetch cycle marker, active low
//   cpu_dout  CPU write data
//   cpu_din   CPU read data
//   wait_n    CPU wait request, active low
//
// Modports:
//   master  CPU side
//   slave   map controller side
// ----------------------------------------------------------------------------
interface cobra_memmap_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] addr_raw;
    logic              mreq_n;
    logic              iorq_n;
    logic              rd_n;
    logic              wr_n;
    logic              m1_n;
    logic [7:0]        cpu_dout;
    logic [7:0]        cpu_din;
    logic              wait_n;

    modport master (
        output addr_raw, mreq_n, iorq_n, rd_n, wr_n, m1_n, cpu_dout,
        input  cpu_din, wait_n
    );

    modport slave (
        input  addr_raw, mreq_n, iorq_n, rd_n, wr_n, m1_n, cpu_dout,
        output cpu_din, wait_n
    );
endinterface

// File: rtl/cobra_memmap.sv
// ----------------------------------------------------------------------------
// cobra_memmap
//
// Purpose:
//   Memory and I/O map controller between the tv80s core and the Cobra1
//   memory and peripheral set. It provides the following functions:
//     - a boot overlay that ORs RELOC_OR into the address until the CPU
//       writes RELOC_PORT. Release is either immediate, or deferred until
//       the next opcode fetch completes (RELOC_MODE).
//     - ROM / VRAM / RAM region decode, with write steering and ROM write
//       protection through a sticky error flag.
//     - per-region wait states, counted from the start of a memory access.
//     - an IO_PORTS-way I/O read mux with one-cycle read strobes.
//
// Ports:
//   clk_cpu       CPU clock
//   rst_n         asynchronous active-low reset
//   bus           CPU bus (slave modport): address, strobes, data, wait_n
//   ram_di        RAM read data
//   rom_di        ROM read data
//   vram_di       VRAM read data
//   io_di         packed I/O read data; source k is at [8k+7:8k]
//   mem_a         relocated address to RAM/VRAM
//   rom_a         ROM address (unrelocated low bits of addr_raw)
//   ram_w         RAM write enable
//   vram_w        VRAM write enable
//   io_rd_stb     one-cycle read strobe per I/O source
//   reloc_active  overlay is in effect
//   rom_wr_err    sticky flag: a write to ROM was attempted
// ----------------------------------------------------------------------------
module cobra_memmap #(
    parameter int              ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] ROM_BASE = 16'hC000,
    parameter int              ROM_AW     = 11,
    parameter logic [ADDR_W-1:0] VRAM_BASE = 16'hF800,
    parameter logic [ADDR_W-1:0] RELOC_OR  = 16'hC000,
    parameter logic [7:0]      RELOC_PORT = 8'h1F,
    parameter int              RELOC_MODE = 0,
    parameter int              IO_PORTS   = 4,
    parameter logic [7:0]      IO_BASE    = 8'hFC,
    parameter int              ROM_WAIT   = 0,
    parameter int              VRAM_WAIT  = 1
) (
    input  logic                  clk_cpu,
    input  logic                  rst_n,
    cobra_memmap_if.slave         bus,
    input  logic [7:0]            ram_di,
    input  logic [7:0]            rom_di,
    input  logic [7:0]            vram_di,
    input  logic [8*IO_PORTS-1:0] io_di,
    output logic [ADDR_W-1:0]     mem_a,
    output logic [ROM_AW-1:0]     rom_a,
    output logic                  ram_w,
    output logic                  vram_w,
    output logic [IO_PORTS-1:0]   io_rd_stb,
    output logic                  reloc_active,
    output logic                  rom_wr_err
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_ARMED,
        ST_NORMAL
    } reloc_state_t;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_ROM,
        REG_VRAM
    } region_t;

    reloc_state_t        state_q, state_d;
    region_t             region;
    logic [2:0]          region_wait;
    logic [2:0]          wait_cnt;
    logic                mreq_n_q, iorq_n_q, m1_n_q;
    logic                acc_start, io_start, trigger, m1_end;
    logic [IO_PORTS-1:0] io_hit;
    logic [7:0]          io_data;
    logic                unused_ok;

    // The write data passes straight to the memories outside this block.
    assign unused_ok = ^bus.cpu_dout;

    assign reloc_active = (state_q != ST_NORMAL);
    assign mem_a        = reloc_active ? (bus.addr_raw | RELOC_OR) : bus.addr_raw;
    assign rom_a        = bus.addr_raw[ROM_AW-1:0];

    // Region decode on the relocated address: ROM wins over VRAM.
    // ROM_BASE is aligned, so an upper-bit match is the whole range test.
    always_comb begin
        region      = REG_RAM;
        region_wait = 3'd0;
        if (mem_a[ADDR_W-1:ROM_AW] == ROM_BASE[ADDR_W-1:ROM_AW]) begin
            region      = REG_ROM;
            region_wait = 3'(ROM_WAIT);
        end else if (mem_a >= VRAM_BASE) begin
            region      = REG_VRAM;
            region_wait = 3'(VRAM_WAIT);
        end
    end

    // I/O source select. Sources that do not match read back as 8'hFF.
    always_comb begin
        io_hit  = '0;
        io_data = 8'hFF;
        for (int k = 0; k < IO_PORTS; k++) begin
            if (bus.addr_raw[7:0] == 8'(IO_BASE + k)) begin
                io_hit[k] = 1'b1;
                io_data   = io_di[8*k +: 8];
            end
        end
    end

    // Read data mux
    always_comb begin
        bus.cpu_din = 8'hFF;
        if (!bus.mreq_n) begin
            case (region)
                REG_ROM:  bus.cpu_din = rom_di;
                REG_VRAM: bus.cpu_din = vram_di;
                default:  bus.cpu_din = ram_di;
            endcase
        end else if (!bus.iorq_n && !bus.rd_n) begin
            bus.cpu_din = io_data;
        end
    end

    assign ram_w  = ~bus.mreq_n & ~bus.wr_n & (region == REG_RAM);
    assign vram_w = ~bus.mreq_n & ~bus.wr_n & (region == REG_VRAM);

    assign acc_start = ~bus.mreq_n & mreq_n_q;
    assign io_start  = ~bus.iorq_n & iorq_n_q & ~bus.rd_n;
    assign trigger   = ~bus.iorq_n & ~bus.wr_n & (bus.addr_raw[7:0] == RELOC_PORT);
    assign m1_end    = bus.m1_n & ~m1_n_q & ~mreq_n_q;

    // wait_n is gated by rst_n so that a reset taken mid-access releases
    // the CPU at once, even though mreq_n may still be low.
    assign bus.wait_n = ~(rst_n & ((acc_start & (region_wait != 3'd0)) | (wait_cnt != 3'd0)));

    // Strobe history used to find access starts and the end of an M1 fetch
    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            mreq_n_q <= 1'b1;
            iorq_n_q <= 1'b1;
            m1_n_q   <= 1'b1;
        end else begin
            mreq_n_q <= bus.mreq_n;
            iorq_n_q <= bus.iorq_n;
            m1_n_q   <= bus.m1_n;
        end
    end

    // The start cycle already drives wait_n low, so the counter holds the
    // remaining W-1 cycles. Later address changes do not reload it.
    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 3'd0;
        end else if (acc_start && region_wait != 3'd0) begin
            wait_cnt <= region_wait - 3'd1;
        end else if (wait_cnt != 3'd0) begin
            wait_cnt <= wait_cnt - 3'd1;
        end
    end

    // Sticky ROM write flag and registered I/O read strobes
    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            rom_wr_err <= 1'b0;
            io_rd_stb  <= '0;
        end else begin
            if (!bus.mreq_n && !bus.wr_n && region == REG_ROM) begin
                rom_wr_err <= 1'b1;
            end
            io_rd_stb <= io_hit & {IO_PORTS{io_start}};
        end
    end

    // Overlay state register
    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Overlay next state. ARMED ignores the trigger, so a trigger held for
    // several cycles only advances out of BOOT once.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: begin
                if (trigger) begin
                    state_d = (RELOC_MODE == 0) ? ST_NORMAL : ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (m1_end) begin
                    state_d = ST_NORMAL;
                end
            end
            default: state_d = ST_NORMAL;
        endcase
    end

endmodule

// File: tb/tb_cobra_memmap.sv
// ----------------------------------------------------------------------------
// tb_cobra_memmap
//
// Purpose:
//   Bench for cobra_memmap. Two instances share one stimulus stream.
//     dut_a  RELOC_MODE=0, VRAM_WAIT=3
//     dut_b  RELOC_MODE=1, VRAM_WAIT=1
//   The driver queues hand-computed expectations tagged with a cycle
//   number. A monitor pops and compares them on the falling edge.
// ----------------------------------------------------------------------------
module tb_cobra_memmap;

    typedef enum int {
        A_MEM_A, A_ROM_A, A_DIN, A_WAIT, A_RELOC, A_RAMW, A_VRAMW, A_ERR, A_STB,
        B_MEM_A, B_DIN, B_WAIT, B_RELOC
    } sig_t;

    typedef struct {
        int          cyc;
        string       name;
        sig_t        sig;
        logic [15:0] exp;
    } exp_t;

    logic        clk_cpu = 1'b0;
    logic        rst_n;
    logic [15:0] addr_raw;
    logic        mreq_n, iorq_n, rd_n, wr_n, m1_n;
    logic [7:0]  cpu_dout;
    logic [7:0]  ram_di, rom_di, vram_di;
    logic [31:0] io_di;

    logic [15:0] mem_a_a, mem_a_b;
    logic [10:0] rom_a_a, rom_a_b;
    logic        ram_w_a, ram_w_b, vram_w_a, vram_w_b;
    logic [3:0]  stb_a, stb_b;
    logic        reloc_a, reloc_b, err_a, err_b;

    int   cycle = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [15:0] mon_act;

    always #5 clk_cpu = ~clk_cpu;

    always @(posedge clk_cpu) cycle <= cycle + 1;

    cobra_memmap_if #(.ADDR_W(16)) bus_a ();
    cobra_memmap_if #(.ADDR_W(16)) bus_b ();

    assign bus_a.addr_raw = addr_raw;
    assign bus_a.mreq_n   = mreq_n;
    assign bus_a.iorq_n   = iorq_n;
    assign bus_a.rd_n     = rd_n;
    assign bus_a.wr_n     = wr_n;
    assign bus_a.m1_n     = m1_n;
    assign bus_a.cpu_dout = cpu_dout;
    assign bus_b.addr_raw = addr_raw;
    assign bus_b.mreq_n   = mreq_n;
    assign bus_b.iorq_n   = iorq_n;
    assign bus_b.rd_n     = rd_n;
    assign bus_b.wr_n     = wr_n;
    assign bus_b.m1_n     = m1_n;
    assign bus_b.cpu_dout = cpu_dout;

    cobra_memmap #(.RELOC_MODE(0), .VRAM_WAIT(3)) dut_a (
        .clk_cpu(clk_cpu), .rst_n(rst_n), .bus(bus_a.slave),
        .ram_di(ram_di), .rom_di(rom_di), .vram_di(vram_di), .io_di(io_di),
        .mem_a(mem_a_a), .rom_a(rom_a_a), .ram_w(ram_w_a), .vram_w(vram_w_a),
        .io_rd_stb(stb_a), .reloc_active(reloc_a), .rom_wr_err(err_a)
    );

    cobra_memmap #(.RELOC_MODE(1), .VRAM_WAIT(1)) dut_b (
        .clk_cpu(clk_cpu), .rst_n(rst_n), .bus(bus_b.slave),
        .ram_di(ram_di), .rom_di(rom_di), .vram_di(vram_di), .io_di(io_di),
        .mem_a(mem_a_b), .rom_a(rom_a_b), .ram_w(ram_w_b), .vram_w(vram_w_b),
        .io_rd_stb(stb_b), .reloc_active(reloc_b), .rom_wr_err(err_b)
    );

    function automatic logic [15:0] actual(input sig_t s);
        case (s)
            A_MEM_A: return mem_a_a;
            A_ROM_A: return {5'd0, rom_a_a};
            A_DIN:   return {8'd0, bus_a.cpu_din};
            A_WAIT:  return {15'd0, bus_a.wait_n};
            A_RELOC: return {15'd0, reloc_a};
            A_RAMW:  return {15'd0, ram_w_a};
            A_VRAMW: return {15'd0, vram_w_a};
            A_ERR:   return {15'd0, err_a};
            A_STB:   return {12'd0, stb_a};
            B_MEM_A: return mem_a_b;
            B_DIN:   return {8'd0, bus_b.cpu_din};
            B_WAIT:  return {15'd0, bus_b.wait_n};
            B_RELOC: return {15'd0, reloc_b};
            default: return 16'hDEAD;
        endcase
    endfunction

    // Monitor: compare every expectation tagged for the current cycle
    always @(negedge clk_cpu) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cycle) begin
            mon_e   = exp_q.pop_front();
            mon_act = actual(mon_e.sig);
            n_cmp   = n_cmp + 1;
            if (mon_e.cyc != cycle) begin
                n_err = n_err + 1;
                $display("[TB] FAIL %s: expectation for cycle %0d not sampled (now %0d)",
                         mon_e.name, mon_e.cyc, cycle);
            end else if (mon_act !== mon_e.exp) begin
                n_err = n_err + 1;
                $display("[TB] FAIL %s (cycle %0d): got %0h, expected %0h",
                         mon_e.name, cycle, mon_act, mon_e.exp);
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] a, input logic mreq, input logic iorq,
                                 input logic rd, input logic wr, input logic m1,
                                 input logic [7:0] dout);
        @(posedge clk_cpu);
        #1;
        addr_raw = a;
        mreq_n   = mreq;
        iorq_n   = iorq;
        rd_n     = rd;
        wr_n     = wr;
        m1_n     = m1;
        cpu_dout = dout;
    endtask

    task automatic idle();
        applyStimulus(16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
    endtask

    task automatic checkOutput(input string name, input sig_t s, input logic [15:0] e);
        exp_q.push_back('{cyc: cycle, name: name, sig: s, exp: e});
    endtask

    initial begin
        rst_n    = 1'b0;
        addr_raw = 16'h0000;
        mreq_n   = 1'b1;
        iorq_n   = 1'b1;
        rd_n     = 1'b1;
        wr_n     = 1'b1;
        m1_n     = 1'b1;
        cpu_dout = 8'h00;
        ram_di   = 8'h11;
        rom_di   = 8'h22;
        vram_di  = 8'h33;
        io_di    = 32'h7766_5A44;

        // Reset state
        idle();
        checkOutput("rst_reloc_a", A_RELOC, 16'h1);
        checkOutput("rst_reloc_b", B_RELOC, 16'h1);
        checkOutput("rst_wait_a",  A_WAIT,  16'h1);
        checkOutput("rst_stb_a",   A_STB,   16'h0);
        checkOutput("rst_err_a",   A_ERR,   16'h0);
        checkOutput("rst_din_a",   A_DIN,   16'h00FF);
        idle();
        rst_n = 1'b1;
        idle();

        // Boot read at 0000 goes to ROM through the overlay
        applyStimulus(16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        checkOutput("boot_mem_a",  A_MEM_A, 16'hC000);
        checkOutput("boot_mem_b",  B_MEM_A, 16'hC000);
        checkOutput("boot_rom_a",  A_ROM_A, 16'h0000);
        checkOutput("boot_din",    A_DIN,   16'h0022);
        checkOutput("boot_wait",   A_WAIT,  16'h1);
        checkOutput("boot_reloc",  A_RELOC, 16'h1);
        idle();

        // OUT (1Fh) held two cycles
        applyStimulus(16'h001F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        checkOutput("out1_reloc_a_same", A_RELOC, 16'h1);
        applyStimulus(16'h001F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        checkOutput("out1_reloc_a_rel",  A_RELOC, 16'h0);
        checkOutput("out1_reloc_b_arm",  B_RELOC, 16'h1);
        idle();

        // M1 fetch at 0005: dut_a reads RAM, dut_b still overlaid to ROM
        applyStimulus(16'h0005, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("m1_mem_a",    A_MEM_A, 16'h0005);
        checkOutput("m1_din_a",    A_DIN,   16'h0011);
        checkOutput("m1_mem_b",    B_MEM_A, 16'hC005);
        checkOutput("m1_din_b",    B_DIN,   16'h0022);
        checkOutput("m1_reloc_b1", B_RELOC, 16'h1);
        applyStimulus(16'h0005, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("m1_reloc_b2", B_RELOC, 16'h1);
        idle();
        idle();
        checkOutput("m1_end_reloc_b", B_RELOC, 16'h0);

        // Second OUT (1Fh) changes nothing
        applyStimulus(16'h001F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        applyStimulus(16'h001F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        idle();
        checkOutput("out2_reloc_a", A_RELOC, 16'h0);
        checkOutput("out2_reloc_b", B_RELOC, 16'h0);

        // VRAM read at F900: 3 wait cycles on dut_a, 1 on dut_b
        applyStimulus(16'hF900, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        checkOutput("vr_wait_a1", A_WAIT,  16'h0);
        checkOutput("vr_wait_b1", B_WAIT,  16'h0);
        checkOutput("vr_din_a",   A_DIN,   16'h0033);
        checkOutput("vr_mem_a",   A_MEM_A, 16'hF900);
        applyStimulus(16'hF900, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        checkOutput("vr_wait_a2", A_WAIT, 16'h0);
        checkOutput("vr_wait_b2", B_WAIT, 16'h1);
        applyStimulus(16'hF900, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        checkOutput("vr_wait_a3", A_WAIT, 16'h0);
        applyStimulus(16'hF900, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        checkOutput("vr_wait_a4", A_WAIT, 16'h1);
        idle();

        // RAM read at 1000: no wait
        applyStimulus(16'h1000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        checkOutput("ram_wait_a", A_WAIT, 16'h1);
        checkOutput("ram_din_a",  A_DIN,  16'h0011);
        applyStimulus(16'h1000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        checkOutput("ram_wait_a2", A_WAIT, 16'h1);
        idle();

        // Write to ROM at C010: blocked, sticky error
        applyStimulus(16'hC010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hAA);
        checkOutput("romw_ramw",  A_RAMW,  16'h0);
        checkOutput("romw_vramw", A_VRAMW, 16'h0);
        checkOutput("romw_err0",  A_ERR,   16'h0);
        idle();
        checkOutput("romw_err1", A_ERR, 16'h1);
        idle();
        checkOutput("romw_err2", A_ERR, 16'h1);

        // Write to VRAM at F810 and RAM at 2000
        applyStimulus(16'hF810, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55);
        checkOutput("vw_vramw", A_VRAMW, 16'h1);
        checkOutput("vw_ramw",  A_RAMW,  16'h0);
        idle();
        idle();
        idle();
        applyStimulus(16'h2000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h66);
        checkOutput("rw_ramw",  A_RAMW,  16'h1);
        checkOutput("rw_vramw", A_VRAMW, 16'h0);
        idle();
        checkOutput("rw_err_held", A_ERR, 16'h1);

        // IN (FDh): source 1
        applyStimulus(16'h00FD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        checkOutput("in_fd_din",  A_DIN, 16'h005A);
        checkOutput("in_fd_stb0", A_STB, 16'h0);
        applyStimulus(16'h00FD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        checkOutput("in_fd_stb1", A_STB, 16'h2);
        idle();
        checkOutput("in_fd_stb2", A_STB, 16'h0);
        checkOutput("idle_din",   A_DIN, 16'h00FF);

        // IN (10h): unmatched
        applyStimulus(16'h0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        checkOutput("in_10_din", A_DIN, 16'h00FF);
        applyStimulus(16'h0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        checkOutput("in_10_stb", A_STB, 16'h0);
        idle();

        // Reset asserted in the middle of a VRAM wait
        applyStimulus(16'hF900, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        checkOutput("mr_wait_a1", A_WAIT, 16'h0);
        applyStimulus(16'hF900, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        checkOutput("mr_wait_a2", A_WAIT, 16'h0);
        @(posedge clk_cpu);
        #1;
        rst_n = 1'b0;
        checkOutput("mr_wait_a",  A_WAIT,  16'h1);
        checkOutput("mr_wait_b",  B_WAIT,  16'h1);
        checkOutput("mr_reloc_a", A_RELOC, 16'h1);
        checkOutput("mr_reloc_b", B_RELOC, 16'h1);
        checkOutput("mr_err_a",   A_ERR,   16'h0);
        idle();
        rst_n = 1'b1;
        idle();
        idle();

        if (exp_q.size() != 0) begin
            n_err = n_err + exp_q.size();
            $display("[TB] FAIL drain: %0d expectations never sampled, expected 0",
                     exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cobra_memmap.md
Name: cobra_memmap

Overview:
Parametrised memory/I-O map controller between the tv80s core and the Cobra1 memory/peripheral set. It replaces the fixed top-level decode. It provides:
- boot-relocation overlay FSM with a selectable release mode
- region decode for ROM, VRAM and RAM with write steering and ROM write protection
- per-region wait-state insertion
- an N-port I/O read mux with read strobes

Parameters:
ADDR_W, 16, CPU address width
ROM_BASE, 16'hC000, ROM region base (aligned to 2**ROM_AW)
ROM_AW, 11, ROM address width; region size 2**ROM_AW
VRAM_BASE, 16'hF800, VRAM region base; region runs to top of address space
RELOC_OR, 16'hC000, value ORed into the address while the overlay is active
RELOC_PORT, 8'h1F, I/O port controlling the overlay
RELOC_MODE, 0, 0 = release on the write; 1 = release after next M1 fetch completes
IO_PORTS, 4, number of I/O read sources (1..8)
IO_BASE, 8'hFC, port of source 0; source k is at IO_BASE+k
ROM_WAIT, 0, wait cycles on ROM access (0..7)
VRAM_WAIT, 1, wait cycles on VRAM access (0..7)

Ports:
clk_cpu  in  1  CPU clock
rst_n  in  1  asynchronous active-low reset
addr_raw  in  ADDR_W  CPU address
mreq_n, iorq_n, rd_n, wr_n, m1_n  in  1 each  CPU strobes
cpu_dout  in  8  CPU write data
ram_di, rom_di, vram_di  in  8 each  memory read data
io_di  in  8*IO_PORTS  packed I/O read data; source k is at bits [8k+7:8k]
mem_a  out  ADDR_W  relocated address to RAM/VRAM
rom_a  out  ROM_AW  ROM address, taken from addr_raw unrelocated
ram_w  out  1  RAM write enable
vram_w  out  1  VRAM write enable
cpu_din  out  8  CPU read data
wait_n  out  1  CPU wait, active low
io_rd_stb  out  IO_PORTS  one-cycle read strobe per source
reloc_active  out  1  overlay state
rom_wr_err  out  1  sticky flag: ROM write attempted

Behaviour:
- Reset (async, rst_n=0):
  - reloc_active=1, FSM=BOOT
  - wait counter=0, wait_n=1, io_rd_stb=0, rom_wr_err=0
  - registered mreq_n/iorq_n history=1
  - Reset mid-access drops wait_n high immediately.
- Address and decode:
  - mem_a = reloc_active ? addr_raw|RELOC_OR : addr_raw.
  - Region decode uses mem_a; the priority is ROM first, then VRAM, then RAM.
  - ROM: ROM_BASE <= mem_a < ROM_BASE+2**ROM_AW.
  - VRAM: mem_a >= VRAM_BASE.
  - RAM: everything else.
- Read data:
  - mreq_n=0: cpu_din = rom_di / vram_di / ram_di according to region.
  - iorq_n=0 && rd_n=0: cpu_din = io_di of the source matching addr_raw[7:0]; 8'hFF if no source matches.
  - Otherwise cpu_din = 8'hFF.
- Writes (combinational):
  - ram_w = ~mreq_n & ~wr_n & region==RAM.
  - vram_w = same with region==VRAM.
  - A write to ROM drives neither enable and sets rom_wr_err on the next edge; it clears only on reset.
- Overlay FSM:
  - States: BOOT (reloc_active=1), ARMED (reloc_active=1), NORMAL (reloc_active=0).
  - Trigger = I/O write with ~iorq_n & ~wr_n & addr_raw[7:0]==RELOC_PORT.
  - BOOT on trigger: RELOC_MODE=0 goes to NORMAL at the next edge; RELOC_MODE=1 goes to ARMED.
  - ARMED goes to NORMAL on the edge where an M1 fetch ends (m1_n rises while mreq_n was low the previous cycle).
  - NORMAL: further triggers are ignored. Only reset returns the FSM to BOOT.
  - A trigger held over several cycles counts once.
- Wait states:
  - Access start = mreq_n low this cycle and high in the registered previous cycle.
  - If the start region's wait count W>0, wait_n goes low combinationally in the start cycle and the counter loads W-1.
  - wait_n stays low while the counter is nonzero; the counter decrements each cycle. Total low time is exactly W cycles.
  - With W=0, wait_n stays 1.
  - The region is sampled at start only. Address changes during the wait do not reload the counter.
  - I/O cycles get no wait states.
- I/O strobes:
  - io_rd_stb[k] pulses for exactly one cycle, registered, on the edge after the start of an I/O read (iorq_n falling with rd_n=0) to source k.
  - Unmatched ports produce no strobe.

Test Plan:
- Reset, then read at 16'h0000 -> mem_a=16'hC000, cpu_din=rom_di, rom_a=11'h000, reloc_active=1, wait_n=1.
- RELOC_MODE=0: OUT (1Fh) -> reloc_active=0 at next edge; a read at 16'h0000 then returns ram_di. A second OUT (1Fh) leaves the state unchanged.
- RELOC_MODE=1: OUT (1Fh) -> reloc_active stays 1 through the following M1 fetch (fetch address mapped to 16'hC0xx), then drops to 0 when that fetch ends.
- VRAM_WAIT=3: memory read at 16'hF900 -> wait_n low for exactly 3 cycles starting in the mreq_n-fall cycle; cpu_din=vram_di. A RAM read at 16'h1000 leaves wait_n at 1.
- Write 8'hAA to 16'hC010 in NORMAL -> ram_w=0, vram_w=0, rom_wr_err=1 and held. Write to 16'hF810 -> vram_w=1, ram_w=0.
- IN from ports FDh and 10h with io_di[15:8]=8'h5A -> port FDh: cpu_din=8'h5A and io_rd_stb=4'b0010 for one cycle. Port 10h: cpu_din=8'hFF and no strobe. Assert rst_n low mid-wait -> wait_n=1 immediately and reloc_active=1.
